// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard unit.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_W      = 2;

  // Forward select encoding; 2'b11 is never produced.
  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

  // Destination metadata carried by each pipeline slot.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_select.sv
// Forward select for one EX operand: EX/MEM producer beats MEM/WB producer.
// Loads in MEM are excluded since their data is not ready until WB.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  stage_info_t           mem_i,
  input  stage_info_t           wb_i,
  output logic [FWD_W-1:0]      fwd
);

  logic mem_hit, wb_hit;
  logic unused_wb_load;

  assign unused_wb_load = wb_i.mem_read;

  assign mem_hit = mem_i.valid && mem_i.reg_write && !mem_i.mem_read &&
                   (mem_i.rd != '0) && (mem_i.rd == ex_rs);
  assign wb_hit  = wb_i.valid && wb_i.reg_write &&
                   (wb_i.rd != '0) && (wb_i.rd == ex_rs);

  // Priority pick: most recent producer wins, x0 never forwarded.
  always_comb begin
    fwd = FWD_RF;
    if (mem_hit)     fwd = FWD_EXMEM;
    else if (wb_hit) fwd = FWD_MEMWB;
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding / hazard control: tracks EX, MEM, WB destination metadata,
// drives the EX operand forward selects and the load-use stall.
// Optional macro RF_BYPASS_EN adds id_bypass_a/b for a read-before-write
// register file; without it the register file must be write-first.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int FWD_W      = hazard_pkg::FWD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [FWD_W-1:0]      forward_a,
  output logic [FWD_W-1:0]      forward_b,
  output logic                  stall,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write
`ifdef RF_BYPASS_EN
  ,
  output logic                  id_bypass_a,
  output logic                  id_bypass_b
`endif
);

  import hazard_pkg::stage_info_t;
  import hazard_pkg::STAGE_BUBBLE;

  stage_info_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0][REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [1:0][FWD_W-1:0]      fwd;
  logic                       rs_match;

  // Load-use: load in EX whose rd feeds either ID source. Squashed ID never stalls.
  assign rs_match = (ex_q.rd == id_rs1) || (ex_q.rd == id_rs2);
  assign stall    = !flush && id_valid && ex_q.valid && ex_q.mem_read &&
                    (ex_q.rd != '0) && rs_match;

  // Next-slot logic: MEM/WB always advance; EX takes a bubble on flush or stall.
  always_comb begin
    mem_d   = ex_q;
    wb_d    = mem_q;
    ex_d    = STAGE_BUBBLE;
    ex_rs_d = '0;
    if (!flush && !stall) begin
      ex_d.valid     = id_valid;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_rs_d[0]     = id_rs1;
      ex_rs_d[1]     = id_rs2;
    end
  end

  // Slot registers; reset clears every slot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= STAGE_BUBBLE;
      ex_rs_q <= '0;
      mem_q   <= STAGE_BUBBLE;
      wb_q    <= STAGE_BUBBLE;
    end else begin
      ex_q    <= ex_d;
      ex_rs_q <= ex_rs_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  // One compare per EX operand (0 = rs1, 1 = rs2); depends on slot state only.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_select u_fwd (
      .ex_rs (ex_rs_q[g]),
      .mem_i (mem_q),
      .wb_i  (wb_q),
      .fwd   (fwd[g])
    );
  end

  assign forward_a    = fwd[0];
  assign forward_b    = fwd[1];
  assign wb_rd        = wb_q.rd;
  assign wb_reg_write = wb_q.valid && wb_q.reg_write;

`ifdef RF_BYPASS_EN
  // Register file reads before it writes, so ID picks up the WB value here.
  assign id_bypass_a = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
  assign id_bypass_b = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);
`endif

`ifndef SYNTHESIS
  // A load in MEM feeding a live EX source means the stall was missed.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(ex_q.valid && mem_q.valid && mem_q.reg_write && mem_q.mem_read &&
                (mem_q.rd != '0) &&
                ((mem_q.rd == ex_rs_q[0]) || (mem_q.rd == ex_rs_q[1]))))
        else $error("load in MEM feeds EX source without a stall");
    end
  end
`endif

endmodule
